// File: rtl/inst_ram_loader.sv
// rtl/inst_ram_loader.sv - UART byte-stream boot loader in front of the instruction RAM
module inst_ram_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_words,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_wea,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic [7:0]            checksum
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_WIDTH:0]   DEPTH    = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_pend;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] clamp_last;
    logic                  start_ok;
    logic                  final_write;
    logic                  byte_ok;

    // Index of the final word: 0 or anything past the RAM depth means "fill the whole RAM".
    always_comb begin
        clamp_last = TOP_ADDR;
        if (load_words != '0 && load_words <= DEPTH) begin
            clamp_last = load_words[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
        end
    end

    // A start request only counts from IDLE; the retiring write of the last word ends the load,
    // and any byte landing in that same cycle is dropped.
    always_comb begin
        start_ok    = (state == S_IDLE) && load_start;
        final_write = (state == S_LOAD) && wr_pend && (wr_addr == last_addr);
        byte_ok     = (state == S_LOAD) && rx_valid && !final_write;
    end

    // Top-level sequencing: IDLE -> LOAD -> DONE (one cycle) -> IDLE.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state     <= S_IDLE;
            last_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state     <= S_LOAD;
                        last_addr <= clamp_last;
                    end
                end
                S_LOAD: begin
                    if (final_write) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte assembly and running checksum; the assembly register is separate from the write
    // register so a byte arriving while a write is pending is never lost.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            asm_word <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (start_ok) begin
            asm_word <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (byte_ok) begin
            asm_word[8*byte_idx +: 8] <= rx_data;
            byte_idx                  <= byte_idx + 2'd1;
            checksum                  <= checksum + rx_data;
        end
    end

    // Write side: a completed word sits in wr_data for exactly one cycle while ram_wea is high,
    // then the address advances.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            wr_pend <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
        end else if (start_ok) begin
            wr_pend <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
        end else if (state == S_LOAD) begin
            if (wr_pend) begin
                wr_pend <= 1'b0;
                if (!final_write) begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                end
            end
            if (byte_ok && byte_idx == 2'd3) begin
                wr_data <= {rx_data, asm_word[23:0]};
                wr_pend <= 1'b1;
            end
        end else begin
            wr_pend <= 1'b0;
        end
    end

    // RAM port mux: the CPU owns the address in IDLE, the loader owns it otherwise.
    always_comb begin
        ram_wea   = (state == S_LOAD) && wr_pend;
        ram_dina  = ram_wea ? wr_data : '0;
        ram_addra = (state == S_IDLE) ? fetch_addr : wr_addr;
        busy      = (state != S_IDLE);
        cpu_hold  = (state != S_IDLE);
        load_done = (state == S_DONE);
    end

endmodule

// File: tb/tb_inst_ram_loader.sv
// tb/tb_inst_ram_loader.sv - self-checking bench for inst_ram_loader
module tb_inst_ram_loader;

    logic        clka = 1'b0;
    logic        rsta_n;
    logic        load_start;
    logic [6:0]  load_words;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [5:0]  fetch_addr;
    logic [5:0]  ram_addra;
    logic [31:0] ram_dina;
    logic        ram_wea;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic [7:0]  checksum;

    inst_ram_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clka       (clka),
        .rsta_n     (rsta_n),
        .load_start (load_start),
        .load_words (load_words),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fetch_addr (fetch_addr),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_wea    (ram_wea),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .load_done  (load_done),
        .checksum   (checksum)
    );

    always #5 clka = ~clka;

    typedef struct {
        string      name;
        logic [6:0] words;
        int         nbytes;
        int         gap;
        bit         ramp;
        int         exp_writes;
        logic [7:0] exp_cs;
    } load_vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    wr_t exp_q[$];

    int         wea_count = 0;
    int         last_wea_cyc = 0;
    int         done_count = 0;
    int         done_cyc = 0;
    logic [7:0] done_cs = '0;
    logic       prev_done = 1'b0;
    logic       hold_after = 1'b1;

    int          tgt;
    int          bk;
    logic [31:0] asm_w;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clka) begin
        if (ram_wea) begin
            wea_count++;
            last_wea_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ram_addra, ram_dina);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (ram_addra !== e.addr || ram_dina !== e.data) begin
                    errors++;
                    $display("FAIL ram_write: got @0x%0h 0x%0h expected @0x%0h 0x%0h",
                             ram_addra, ram_dina, e.addr, e.data);
                end
            end
        end else if (ram_dina !== 32'h0) begin
            checks++;
            errors++;
            $display("FAIL dina_idle: got 0x%0h expected 0x0", ram_dina);
        end
        if (prev_done) hold_after = cpu_hold;
        prev_done = load_done;
        if (load_done) begin
            done_count++;
            done_cyc = cyc;
            done_cs  = checksum;
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic begin_load(input logic [6:0] w);
        tgt        = (w == 0 || w > 64) ? 64 : int'(w);
        bk         = 0;
        asm_w      = '0;
        hold_after = 1'b1;
        load_words = w;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'h1);
        check("hold_after_start", {31'b0, cpu_hold}, 32'h1);
    endtask

    task automatic send_tracked(input logic [7:0] b);
        asm_w[8*(bk%4) +: 8] = b;
        if (bk % 4 == 3 && bk / 4 < tgt) begin
            wr_t e;
            e.addr = 6'(bk / 4);
            e.data = asm_w;
            exp_q.push_back(e);
        end
        bk++;
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic finish_load(input string nm, input int done0, input int wea0,
                               input int exp_writes, input logic [7:0] exp_cs);
        int t;
        t = 0;
        while (done_count == done0 && t < 40) begin
            tick();
            t++;
        end
        if (done_count == done0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no load_done within 40 cycles", nm);
        end
        repeat (3) tick();
        check({nm, "_done_pulses"}, 32'(done_count - done0), 32'd1);
        check({nm, "_checksum"}, {24'b0, done_cs}, {24'b0, exp_cs});
        check({nm, "_writes"}, 32'(wea_count - wea0), 32'(exp_writes));
        check({nm, "_done_latency"}, 32'(done_cyc - last_wea_cyc), 32'd1);
        check({nm, "_hold_drop"}, {31'b0, hold_after}, 32'h0);
        check({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({nm, "_busy_idle"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        load_vec_t  vec[5];
        logic [7:0] fixed[8];
        int         d0;
        int         w0;
        logic [7:0] cs_hold;

        fixed = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        vec[0] = '{"spaced2",  7'd2,  8,   2, 1'b0, 2,  8'h4C};
        vec[1] = '{"full0",    7'd0,  256, 0, 1'b1, 64, 8'h80};
        vec[2] = '{"clamp70",  7'd70, 264, 0, 1'b1, 64, 8'h80};
        vec[3] = '{"one_word", 7'd1,  4,   1, 1'b1, 1,  8'h06};
        vec[4] = '{"three",    7'd3,  12,  0, 1'b1, 3,  8'h42};

        rsta_n     = 1'b0;
        load_start = 1'b0;
        load_words = '0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        fetch_addr = 6'h15;
        @(negedge clka);
        check("rst_addra", {26'b0, ram_addra}, 32'h15);
        check("rst_dina", ram_dina, 32'h0);
        check("rst_wea", {31'b0, ram_wea}, 32'h0);
        check("rst_hold", {31'b0, cpu_hold}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, load_done}, 32'h0);
        check("rst_checksum", {24'b0, checksum}, 32'h0);
        fetch_addr = 6'h2A;
        #1;
        check("fetch_follow", {26'b0, ram_addra}, 32'h2A);
        tick();
        rsta_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            d0 = done_count;
            w0 = wea_count;
            begin_load(vec[i].words);
            for (int k = 0; k < vec[i].nbytes; k++) begin
                send_tracked(vec[i].ramp ? 8'(k) : fixed[k % 8]);
                repeat (vec[i].gap) tick();
            end
            finish_load(vec[i].name, d0, w0, vec[i].exp_writes, vec[i].exp_cs);
        end

        // rx traffic while idle must not write or disturb the checksum
        w0      = wea_count;
        cs_hold = checksum;
        for (int k = 0; k < 6; k++) begin
            rx_data  = 8'hA5 + 8'(k);
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        tick();
        check("idle_rx_writes", 32'(wea_count - w0), 32'd0);
        check("idle_rx_checksum", {24'b0, checksum}, {24'b0, cs_hold});
        fetch_addr = 6'h07;
        #1;
        check("idle_fetch", {26'b0, ram_addra}, 32'h07);

        // a second load_start mid-load is ignored; writes continue at the next address
        d0 = done_count;
        w0 = wea_count;
        begin_load(7'd2);
        for (int k = 0; k < 5; k++) send_tracked(8'h10 + 8'(k));
        load_words = 7'd1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 5; k < 8; k++) send_tracked(8'h10 + 8'(k));
        finish_load("restart_ignored", d0, w0, 2, 8'h9C);

        // asynchronous reset in the middle of a load
        begin_load(7'd2);
        for (int k = 0; k < 5; k++) send_tracked(8'h20 + 8'(k));
        fetch_addr = 6'h33;
        rsta_n     = 1'b0;
        #1;
        check("midrst_addra", {26'b0, ram_addra}, 32'h33);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_hold", {31'b0, cpu_hold}, 32'h0);
        check("midrst_wea", {31'b0, ram_wea}, 32'h0);
        check("midrst_checksum", {24'b0, checksum}, 32'h0);
        exp_q.delete();
        tick();
        rsta_n = 1'b1;
        tick();
        d0 = done_count;
        w0 = wea_count;
        begin_load(7'd1);
        send_tracked(8'h01);
        send_tracked(8'h02);
        send_tracked(8'h03);
        send_tracked(8'h04);
        finish_load("post_reset", d0, w0, 1, 8'h0A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
